// File: rtl/lfsr_pkg.sv
//==============================================================================
// Module      : lfsr_pkg
// Description : Shared LFSR width, tap mask and checker state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps on bits 7, 5, 4 and 3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
//==============================================================================
// Module      : lfsr_step
// Description : Combinational single step of the Fibonacci LFSR, next(x).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int              W    = LFSR_W,
    parameter logic [W-1:0]    TAPS = LFSR_TAPS
) (
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt
);

    assign nxt = {cur[W-2:0], ^(cur & TAPS)};

endmodule

`default_nettype wire

// File: rtl/lfsr_checker.sv
//==============================================================================
// Module      : lfsr_checker
// Description : Self-synchronising checker for the 8-bit LFSR stream with
//               lock tracking, error pulse and optional saturating error count
//               (err_count built only when LFSR_CHECKER_STATS_EN is defined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
    output logic              locked,
    output logic              err,
    output logic              zero_seen,
    output logic [ERR_W-1:0]  err_count
);

    chk_state_t        state, state_d;
    logic [LFSR_W-1:0] pred, pred_d;
    logic [LFSR_W-1:0] in_next, pred_next;
    logic [3:0]        hits, hits_d, miss, miss_d;
    logic [3:0]        hits_inc, miss_inc;
    logic              in_zero, in_match;
    logic              err_d, zero_d;

    lfsr_step u_step_in   (.cur(in_data), .nxt(in_next));
    lfsr_step u_step_pred (.cur(pred),    .nxt(pred_next));

    assign in_zero  = (in_data == '0);
    assign in_match = (in_data == pred);
    assign hits_inc = hits + 4'd1;
    assign miss_inc = miss + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            pred      <= '0;
            hits      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            zero_seen <= 1'b0;
        end else begin
            state     <= state_d;
            pred      <= pred_d;
            hits      <= hits_d;
            miss      <= miss_d;
            locked    <= (state_d == LOCKED);
            err       <= err_d;
            zero_seen <= zero_d;
        end
    end

    always_comb begin
        state_d = state;
        pred_d  = pred;
        hits_d  = hits;
        miss_d  = miss;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (!in_zero) begin
                        pred_d  = in_next;
                        hits_d  = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_zero) begin
                        state_d = HUNT;
                    end else if (in_match) begin
                        pred_d = in_next;
                        hits_d = hits_inc;
                        if (hits_inc == 4'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        pred_d = in_next;
                        hits_d = '0;
                    end
                end
                LOCKED: begin
                    // Freewheel on the prediction; a bad word never re-seeds
                    pred_d = pred_next;
                    if (in_match) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc == 4'(LOSS_COUNT)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        err_d  = in_valid && (state == LOCKED) && !in_match;
        zero_d = in_valid && in_zero;
    end

`ifdef LFSR_CHECKER_STATS_EN
    logic [ERR_W-1:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_d && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign err_count = err_cnt;
`else
    assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
//==============================================================================
// Module      : tb_lfsr_checker
// Description : Self-checking bench for lfsr_checker (default parameters).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lfsr_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
    localparam int ERR_W  = 16;
`ifdef LFSR_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             locked, err, zero_seen;
    logic [ERR_W-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    lfsr_checker #(
        .LOCK_COUNT(LOCK_N),
        .LOSS_COUNT(LOSS_N),
        .ERR_W     (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .locked   (locked),
        .err      (err),
        .zero_seen(zero_seen),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nx(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether a seed exists, the run of good words,
    // lock status and consecutive misses while locked.
    bit m_locked = 0, m_seeded = 0;
    int m_pred = 0, m_run = 0, m_miss = 0, m_errs = 0;
    bit e_locked = 0, e_err = 0, e_zero = 0;

    always @(posedge clk) begin
        e_err  = 0;
        e_zero = 0;
        if (rst) begin
            m_locked = 0; m_seeded = 0; m_pred = 0; m_run = 0; m_miss = 0; m_errs = 0;
        end else if (in_valid) begin
            e_zero = (in_data == 8'h00);
            if (m_locked) begin
                if (in_data == m_pred[7:0]) m_miss = 0;
                else begin
                    e_err = 1;
                    if (m_errs < (1 << ERR_W) - 1) m_errs++;
                    m_miss++;
                end
                m_pred = nx(m_pred[7:0]);
                if (m_miss == LOSS_N) begin
                    m_locked = 0;
                    m_seeded = 0;
                end
            end else if (in_data == 8'h00) begin
                m_seeded = 0;
            end else if (m_seeded && in_data == m_pred[7:0]) begin
                m_run++;
                m_pred = nx(in_data);
                if (m_run == LOCK_N) begin
                    m_locked = 1;
                    m_miss   = 0;
                end
            end else begin
                m_seeded = 1;
                m_run    = 0;
                m_pred   = nx(in_data);
            end
        end
        e_locked = m_locked;
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_locked",    locked,         e_locked);
            chk("model_err",       err,            e_err);
            chk("model_zero_seen", zero_seen,      e_zero);
            chk("model_err_count", int'(err_count), STATS ? m_errs : 0);
        end
    end

    logic [7:0] seq;

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic send_true();
        drive(1'b1, seq);
        seq = nx(seq);
    endtask

    task automatic send_wrong();
        drive(1'b1, seq ^ 8'h01);
        seq = nx(seq);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        checking = 1'b1;
        chk("reset_locked",    locked,          0);
        chk("reset_err",       err,             0);
        chk("reset_zero_seen", zero_seen,       0);
        chk("reset_err_count", int'(err_count), 0);

        // Zero word while hunting
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        chk("hunt_zero_pulse", zero_seen, 1);
        chk("hunt_zero_err",   err,       0);

        // Lock on the literal stream 93 26 4D 9B 37
        drive(1'b1, 8'h93); drive(1'b1, 8'h26); drive(1'b1, 8'h4D); drive(1'b1, 8'h9B);
        drive(1'b1, 8'h37);
        chk("not_locked_after_4", locked, 0);
        drive(1'b0, 8'h00);
        chk("locked_after_5", locked, 1);
        seq = 8'h6E;

        // One true word, then a zero in place of the next true word
        send_true();
        drive(1'b1, 8'h00);
        seq = nx(seq);
        drive(1'b0, 8'h00);
        chk("zero_err",        err,             1);
        chk("zero_zero_seen",  zero_seen,       1);
        chk("zero_locked",     locked,          1);
        chk("zero_err_count",  int'(err_count), STATS ? 1 : 0);
        send_true();
        drive(1'b0, 8'h00);
        chk("after_zero_match", err, 0);

        // Three consecutive wrong words drop lock
        send_wrong(); send_wrong();
        chk("still_locked_2_miss", locked, 1);
        send_wrong();
        drive(1'b0, 8'h00);
        chk("loss_err",       err,             1);
        chk("loss_locked",    locked,          0);
        chk("loss_err_count", int'(err_count), STATS ? 4 : 0);
        repeat (4) send_true();
        drive(1'b0, 8'h00);
        chk("relock_not_yet", locked, 0);
        send_true();
        drive(1'b0, 8'h00);
        chk("relock", locked, 1);

        // Re-seed in VERIFY after two matches
        do_reset();
        seq = 8'h93;
        repeat (3) send_true();
        seq = 8'h55;
        send_true();
        chk("reseed_no_err", err, 0);
        repeat (3) send_true();
        drive(1'b0, 8'h00);
        chk("reseed_3_matches", locked, 0);
        send_true();
        drive(1'b0, 8'h00);
        chk("reseed_4_matches", locked, 1);

        // Valid toggling every other cycle
        do_reset();
        seq = 8'h93;
        repeat (4) begin send_true(); drive(1'b0, 8'h00); end
        chk("gap_not_locked", locked, 0);
        send_true();
        drive(1'b0, 8'h00);
        chk("gap_locked", locked, 1);

        // Three isolated errors while locked, then reset
        repeat (3) begin send_wrong(); send_true(); end
        drive(1'b0, 8'h00);
        chk("pre_rst_locked",    locked,          1);
        chk("pre_rst_err_count", int'(err_count), STATS ? 3 : 0);
        do_reset();
        chk("rst_locked",    locked,          0);
        chk("rst_err_count", int'(err_count), 0);
        seq = 8'h93;
        repeat (4) send_true();
        drive(1'b0, 8'h00);
        chk("rst_hunt_4", locked, 0);
        send_true();
        drive(1'b0, 8'h00);
        chk("rst_hunt_5", locked, 1);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
